voice_mix_sequencer: RTL and testbench
======================================

VOICE_MIX_SEQUENCER -- requirements
Module: voice_mix_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port divide_now  input  1  one-cycle sample-rate strobe from the sample-rate divider; starts a frame.
REQ-004 SHALL have port voice_en  input  4  per-voice enable; bit i enables voice i.
REQ-005 SHALL have port ws_req  output  1  request to the shared wave-shaper; held high until acknowledged or timed out.
REQ-006 SHALL have port ws_voice  output  2  voice index being requested; valid while ws_req=1.
REQ-007 SHALL have port ws_ack  input  1  wave-shaper acknowledge; ws_sample is valid in the same cycle.
REQ-008 SHALL have port ws_sample  input  8  unsigned sample for voice ws_voice.
REQ-009 SHALL have port mix_out  output  10  unsigned sum of the frame's voice samples; held between frames.
REQ-010 SHALL have port mix_valid  output  1  one-cycle pulse when mix_out updates.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port overrun  output  1  sticky: divide_now arrived while busy.
REQ-013 SHALL have port ack_timeout  output  1  sticky: a request went unacknowledged for 16 cycles.
REQ-014 SHALL have port clr_err  input  1  clears overrun and ack_timeout.

Function
REQ-015 SHALL implement states IDLE, SCAN, REQ, DONE.
REQ-016 IDLE: on divide_now=1, SHALL latch voice_en into en_q, clear accumulator and idx to 0, and go to SCAN.
REQ-017 SCAN: if en_q[idx]=1, SHALL go to REQ; otherwise, if idx=3, go to DONE, else increment idx and stay in SCAN.
REQ-018 REQ: ws_req=1 and ws_voice=idx; on ws_ack=1, SHALL add ws_sample to the accumulator, then go to DONE if idx=3, else increment idx and go to SCAN.
REQ-019 REQ: a 4-bit wait counter SHALL be cleared on entry; if it reaches 15 with ws_ack=0, SHALL contribute 0, set ack_timeout, and advance as on an acknowledge.
REQ-020 DONE: SHALL register mix_out=accumulator, assert mix_valid for exactly the next cycle, and return to IDLE.
REQ-021 Accumulator SHALL be 10-bit unsigned, zero-extending ws_sample; the maximum sum 4*255=1020 SHALL never wrap.
REQ-022 Latency: divide_now sampled in cycle N with en_q=0000 SHALL give mix_valid in cycle N+6.
REQ-023 Latency: all voices enabled with ws_ack in the first REQ cycle SHALL give mix_valid in cycle N+10.
REQ-024 divide_now=1 in any state other than IDLE SHALL be ignored for sequencing and SHALL set overrun.
REQ-025 Simultaneous set and clr_err on a sticky flag: set SHALL win.
REQ-026 Changes on voice_en during a frame SHALL NOT affect that frame, because en_q is used.
REQ-027 ws_ack while ws_req=0 SHALL be ignored.
REQ-028 ws_req, ws_voice, busy and mix_valid SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-029 n_rst=0 SHALL asynchronously force state IDLE and set idx, en_q, accumulator, wait counter, mix_out, mix_valid, overrun and ack_timeout all to 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no mix_valid pulse; the first frame after reset starts only on a new divide_now.

Structure
REQ-031 Shared package synth_pkg SHALL hold the state enum and constants NUM_VOICES=4, SAMPLE_W=8, MIX_W=10 and ACK_TIMEOUT=16.
REQ-032 The block SHALL have no sub-modules; the sample-rate divider and the wave-shaper SHALL be instantiated by the parent.

Verification
REQ-033 Bench SHALL drive voice_en=0000 with a divide_now pulse in cycle N -> mix_valid in cycle N+6, mix_out=0, ws_req never high.
REQ-034 Bench SHALL drive voice_en=1111 with immediate ack and samples 255,255,255,255 -> mix_out=1020 with mix_valid in N+10, and ws_voice sequence 0,1,2,3.
REQ-035 Bench SHALL drive voice_en=0101 with ack delayed 3 cycles and samples 10,20 -> mix_out=30, and requests issued only for voices 0 and 2.
REQ-036 Bench SHALL never ack voice 1 with voice_en=0011 and voice-0 sample 7 -> ws_req for voice 1 held 16 cycles, ack_timeout=1, mix_out=7.
REQ-037 Bench SHALL pulse divide_now during REQ, then clr_err together with a second overrun event -> overrun=1 after both events; a later clr_err alone -> overrun=0.
REQ-038 Bench SHALL assert n_rst=0 during a REQ state -> all outputs 0 immediately, with no mix_valid pulse after reset release until the next divide_now.

Source files
------------

// File: rtl/synth_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : synth_pkg
// Description : Shared types and sizing constants for the voice mixing path.
//               Holds the sequencer state encoding, voice count, sample and
//               mix widths, and the wave-shaper acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

  localparam int NUM_VOICES  = 4;
  localparam int SAMPLE_W    = 8;
  localparam int MIX_W       = 10;
  localparam int ACK_TIMEOUT = 16;

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT);

  // Highest voice index and the last wait-count value before giving up.
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : synth_pkg
`default_nettype wire

// File: rtl/voice_mix_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : voice_mix_sequencer
// Description : Per-frame voice mixer. On each sample-rate strobe it walks the
//               enabled voices in index order, fetches one sample per voice
//               from a shared wave-shaper over a req/ack handshake, sums the
//               samples and presents the total with a one-cycle valid pulse.
//               A request that stays unacknowledged for ACK_TIMEOUT cycles
//               contributes zero and raises a sticky error flag.
// Revision    : 1.0 - initial release
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   divide_now  in   sample-rate strobe, starts a frame when idle
//   voice_en    in   per-voice enable, captured at frame start
//   ws_req      out  wave-shaper request, held until ack or timeout
//   ws_voice    out  voice index of the current request
//   ws_ack      in   wave-shaper acknowledge, ws_sample valid with it
//   ws_sample   in   unsigned sample for ws_voice
//   mix_out     out  sum of the last frame's samples, held between frames
//   mix_valid   out  one-cycle pulse when mix_out updates
//   busy        out  frame in progress
//   overrun     out  sticky: strobe arrived while busy
//   ack_timeout out  sticky: a request timed out
//   clr_err     in   clears the sticky flags (a same-cycle set wins)
// ============================================================================
module voice_mix_sequencer
  import synth_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  divide_now,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic                  ws_req,
  output logic [IDX_W-1:0]      ws_voice,
  input  logic                  ws_ack,
  input  logic [SAMPLE_W-1:0]   ws_sample,
  output logic [MIX_W-1:0]      mix_out,
  output logic                  mix_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  ack_timeout,
  input  logic                  clr_err
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [MIX_W-1:0]      acc_q, acc_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [MIX_W-1:0]      mix_out_q, mix_out_d;
  logic                  mix_valid_q, mix_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  ack_to_q, ack_to_d;

  logic                  advance;
  logic                  timeout_set;
  logic                  overrun_set;

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    en_d        = en_q;
    acc_d       = acc_q;
    wait_d      = '0;          // counter only survives while waiting in REQ
    advance     = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (divide_now) begin
          en_d    = voice_en;  // frame works from this snapshot only
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (en_q[idx_q]) begin
          state_d = ST_REQ;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_REQ: begin
        // An ack in the final wait cycle still counts as a real sample.
        if (ws_ack) begin
          acc_d   = acc_q + {{(MIX_W - SAMPLE_W){1'b0}}, ws_sample};
          advance = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          advance     = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end

        if (advance) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Result register and sticky error flags
  // --------------------------------------------------------------------------
  always_comb begin
    mix_out_d   = (state_q == ST_DONE) ? acc_q : mix_out_q;
    mix_valid_d = (state_q == ST_DONE);
    overrun_set = divide_now && (state_q != ST_IDLE);
    // Set takes priority over a simultaneous clear.
    overrun_d   = overrun_set | (overrun_q & ~clr_err);
    ack_to_d    = timeout_set | (ack_to_q  & ~clr_err);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      wait_q      <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      ack_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      acc_q       <= acc_d;
      wait_q      <= wait_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
      ack_to_q    <= ack_to_d;
    end
  end

  // Handshake and status outputs come from registers only.
  assign ws_req      = (state_q == ST_REQ);
  assign ws_voice    = idx_q;
  assign busy        = (state_q != ST_IDLE);
  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;
  assign overrun     = overrun_q;
  assign ack_timeout = ack_to_q;

endmodule : voice_mix_sequencer
`default_nettype wire

// File: tb/tb_voice_mix_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_voice_mix_sequencer
// Description : Self-checking bench for voice_mix_sequencer. A wave-shaper
//               responder acknowledges each voice after a per-voice delay;
//               expected sums, latencies, request order and hold lengths are
//               derived from the frame rules with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_mix_sequencer;
  import synth_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       divide_now = 1'b0;
  logic [3:0] voice_en = 4'd0;
  logic       ws_req;
  logic [1:0] ws_voice;
  logic       ws_ack = 1'b0;
  logic [7:0] ws_sample = 8'd0;
  logic [9:0] mix_out;
  logic       mix_valid;
  logic       busy;
  logic       overrun;
  logic       ack_timeout;
  logic       clr_err = 1'b0;

  voice_mix_sequencer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .divide_now  (divide_now),
    .voice_en    (voice_en),
    .ws_req      (ws_req),
    .ws_voice    (ws_voice),
    .ws_ack      (ws_ack),
    .ws_sample   (ws_sample),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun),
    .ack_timeout (ack_timeout),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Per-voice responder behaviour: ack after dly[v] waiting cycles (a value
  // of ACK_TIMEOUT or more means never), returning smp[v].
  int dly[4];
  int smp[4];

  int obs_voice[$];
  int obs_len[$];
  int req_cnt = 0;

  always @(negedge clk) begin
    if (ws_req === 1'b1) begin
      if (req_cnt == 0) obs_voice.push_back(int'(ws_voice));
      ws_ack    = (req_cnt == dly[ws_voice]);
      ws_sample = ws_ack ? 8'(smp[ws_voice]) : 8'($urandom);
      req_cnt++;
    end else begin
      if (req_cnt != 0) obs_len.push_back(req_cnt);
      req_cnt   = 0;
      // Stray acks while nothing is requested must be ignored by the DUT.
      ws_ack    = 1'($urandom_range(0, 1));
      ws_sample = 8'($urandom);
    end
  end

  // Reference model of one frame.
  int exp_sum, exp_lat, exp_to;
  int exp_voice[$];
  int exp_len[$];
  int start_cyc;

  task automatic start_frame(input logic [3:0] en);
    obs_voice.delete();
    obs_len.delete();
    exp_voice.delete();
    exp_len.delete();
    exp_sum = 0;
    exp_to  = 0;
    // One scan cycle per voice, one DONE cycle, then the valid cycle.
    exp_lat = NUM_VOICES + 2;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (en[v]) begin
        exp_voice.push_back(v);
        if (dly[v] < ACK_TIMEOUT) begin
          exp_sum += smp[v];
          exp_len.push_back(dly[v] + 1);
        end else begin
          exp_to = 1;
          exp_len.push_back(ACK_TIMEOUT);
        end
        exp_lat += exp_len[$];
      end
    end
    divide_now = 1'b1;
    voice_en   = en;
    start_cyc  = cyc;
    @(negedge clk);
    divide_now = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int exp_ovr);
    int waited = 0;
    while (mix_valid !== 1'b1 && waited < 500) begin
      voice_en = 4'($urandom);   // must not disturb the running frame
      @(negedge clk);
      waited++;
    end
    check({tag, ".valid"},   32'(mix_valid), 32'd1);
    check({tag, ".latency"}, cyc - start_cyc, exp_lat);
    check({tag, ".mix_out"}, 32'(mix_out), exp_sum);
    check({tag, ".ack_to"},  32'(ack_timeout), exp_to);
    check({tag, ".overrun"}, 32'(overrun), exp_ovr);
    check({tag, ".n_req"},   obs_voice.size(), exp_voice.size());
    check({tag, ".n_len"},   obs_len.size(), exp_len.size());
    for (int i = 0; i < exp_voice.size() && i < obs_voice.size(); i++)
      check($sformatf("%s.voice%0d", tag, i), obs_voice[i], exp_voice[i]);
    for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++)
      check($sformatf("%s.hold%0d", tag, i), obs_len[i], exp_len[i]);
    @(negedge clk);
    check({tag, ".pulse_end"}, 32'(mix_valid), 32'd0);
    check({tag, ".idle"},      32'(busy), 32'd0);
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int w = 0;
    while (ws_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".req_seen"}, 32'(ws_req), 32'd1);
  endtask

  initial begin
    int seen_valid;
    int seen_busy;
    logic [3:0] en;

    dly = '{0, 0, 0, 0};
    smp = '{0, 0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.ws_req",  32'(ws_req), 32'd0);
    check("rst.busy",    32'(busy), 32'd0);
    check("rst.valid",   32'(mix_valid), 32'd0);
    check("rst.mix_out", 32'(mix_out), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    check("rst.ack_to",  32'(ack_timeout), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // No voices: six-cycle latency, zero sum, no requests
    start_frame(4'b0000);
    finish_frame("none", 0);

    // All voices, immediate ack, full-scale samples
    dly = '{0, 0, 0, 0};
    smp = '{255, 255, 255, 255};
    start_frame(4'b1111);
    finish_frame("full", 0);

    // Voices 0 and 2, ack after three waiting cycles
    dly = '{3, 3, 3, 3};
    smp = '{10, 99, 20, 99};
    start_frame(4'b0101);
    finish_frame("sparse", 0);

    // Voice 1 never acknowledged
    dly = '{0, 255, 0, 0};
    smp = '{7, 50, 0, 0};
    start_frame(4'b0011);
    finish_frame("timeout", 0);
    clear_err();
    check("timeout.cleared", 32'(ack_timeout), 32'd0);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        dly[v] = ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, 6));
        smp[v] = int'($urandom_range(0, 255));
      end
      en = 4'($urandom);
      clear_err();
      start_frame(en);
      finish_frame($sformatf("rand%0d", f), 0);
    end

    // Overrun: strobe during REQ, then strobe together with clear
    dly = '{4, 4, 4, 4};
    smp = '{1, 2, 3, 4};
    clear_err();
    start_frame(4'b1111);
    wait_req("ovr");
    divide_now = 1'b1;
    @(negedge clk);
    divide_now = 1'b0;
    check("ovr.first", 32'(overrun), 32'd1);
    @(negedge clk);
    divide_now = 1'b1;
    clr_err    = 1'b1;
    @(negedge clk);
    divide_now = 1'b0;
    clr_err    = 1'b0;
    check("ovr.set_wins", 32'(overrun), 32'd1);
    finish_frame("ovr", 1);
    clear_err();
    check("ovr.cleared", 32'(overrun), 32'd0);

    // Asynchronous reset in the middle of a request
    dly = '{8, 8, 8, 8};
    smp = '{11, 22, 33, 44};
    start_frame(4'b1111);
    wait_req("arst");
    divide_now = 1'b1;
    @(negedge clk);
    divide_now = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("arst.ws_req",   32'(ws_req), 32'd0);
    check("arst.ws_voice", 32'(ws_voice), 32'd0);
    check("arst.busy",     32'(busy), 32'd0);
    check("arst.valid",    32'(mix_valid), 32'd0);
    check("arst.mix_out",  32'(mix_out), 32'd0);
    check("arst.overrun",  32'(overrun), 32'd0);
    check("arst.ack_to",   32'(ack_timeout), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    seen_valid = 0;
    seen_busy  = 0;
    repeat (40) begin
      @(negedge clk);
      if (mix_valid === 1'b1) seen_valid++;
      if (busy === 1'b1) seen_busy++;
    end
    check("arst.no_valid", seen_valid, 0);
    check("arst.no_busy",  seen_busy, 0);

    dly = '{2, 0, 5, 1};
    smp = '{100, 200, 150, 250};
    start_frame(4'b1010);
    finish_frame("post_rst", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_voice_mix_sequencer
`default_nettype wire
